ram128x32_burst_ctrl: RTL and testbench
=======================================

# ram128x32_burst_ctrl

Burst DMA front-end that owns the single-port port of the 128x32 synchronous RAM, which has a registered read. It accepts fill or dump commands and streams words into the RAM from a valid/ready input. It streams words out of the RAM to a valid/ready output, absorbing the RAM's 1-cycle read latency so downstream back-pressure never loses data. It sits directly upstream of the RAM: the RAM's clk/we/address/d/q connect one-to-one to this block's `ram_*` ports.

## Interface
- `DATA_WIDTH`, 32, word width; must match RAM
- `ADDR_WIDTH`, 7, RAM address bits; depth = 2**ADDR_WIDTH
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  block idle and can accept a command
- `cmd_wr`  in  1  1 = fill (stream into RAM), 0 = dump (RAM to stream)
- `cmd_addr`  in  ADDR_WIDTH  start address
- `cmd_len`  in  ADDR_WIDTH+1  word count
- `s_valid` / `s_ready` / `s_data`  in/out/in  1/1/DATA_WIDTH  fill stream
- `m_valid` / `m_ready` / `m_data` / `m_last`  out/in/out/out  1/1/DATA_WIDTH/1  dump stream
- `done`  out  1  one-cycle pulse when a command completes
- `ram_we`  out  1  to RAM `we`
- `ram_address`  out  ADDR_WIDTH  to RAM `address`
- `ram_d`  out  DATA_WIDTH  to RAM `d`
- `ram_q`  in  DATA_WIDTH  from RAM `q`

## Operation
- States: IDLE, WR, RD_ISSUE, RD_DRAIN.
  - IDLE: `cmd_ready`=1. A handshake latches addr/len and enters WR or RD_ISSUE.
  - `cmd_len`=0: the command is accepted, no beats occur, and `done` pulses next cycle.
  - `cmd_len` > depth is clamped to depth.
- WR:
  - `s_ready`=1.
  - Each `s_valid&s_ready` beat drives `ram_we`=1, `ram_address`=cur addr, `ram_d`=`s_data` in the same cycle.
  - Then addr+1 mod depth (wraps 127→0) and remaining−1.
  - After the last beat, go to IDLE with `done`=1 in that next cycle.
- RD_ISSUE:
  - Drive `ram_address`=cur addr and issue a read when `occupancy + inflight − pop < 2`.
  - `occupancy` = skid buffer entries (0..2); `inflight` = read issued last cycle (0/1); `pop` = `m_valid&m_ready` this cycle.
  - Captures `ram_q` into the buffer the cycle after issue.
  - After the last issue, go to RD_DRAIN.
- RD_DRAIN: wait until the buffer is empty and nothing is in flight, then go to IDLE with `done`=1.
- `m_valid` = buffer non-empty.
- `m_data` = buffer head.
- `m_last` = 1 on the head word that is the command's final word.
- `ram_we`=0 in every cycle that is not a write beat.
- `ram_address` holds its last value in IDLE.
- `ram_d` = `s_data` always.
- `s_ready`=0 outside WR.
- Reset:
  - While `rst_n`=0: state→IDLE, buffer flushed, in-flight read discarded, counters cleared.
  - Reset values: `cmd_ready`, `s_ready`, `m_valid`, `m_last`, `done`, `ram_we` = 0; `ram_address` = 0; `m_data` = 0.
  - Reset mid-burst aborts with no `done`.

## Timing
- Let A = the cycle of the command handshake.
- Fill: `s_ready` is first high in A+1; 1 word/cycle sustained; `done` falls in the cycle after the last beat, and `cmd_ready` is high in that same cycle.
- Dump:
  - First read address in A+1.
  - `ram_q` valid in A+2.
  - First `m_valid` in A+3.
  - With `m_ready` held at 1: 1 word/cycle, `len`+2 cycles from A+1 to the last beat.
- Back-pressure: with `m_ready`=0, at most 2 words are buffered; no read is issued that could overflow; no word is lost or duplicated.
- Back-to-back commands: the next handshake can occur in the same cycle as `done`.

## Structure
- Package `ram_ctrl_pkg`: state enum, `DEPTH` = 2**ADDR_WIDTH, `LEN_W` = ADDR_WIDTH+1.
- Sub-module `ram_rd_skid`: 2-entry buffer with push (`ram_q`, last flag), pop (`m_ready`), and an occupancy output.
- The RAM is not instantiated inside; the bench instantiates the 128x32 RAM alongside.

## Test plan
- Fill at addr 5, len 4 (data 0xA0..0xA3), then dump addr 5, len 4 with `m_ready`=1 → `m_data` 0xA0..0xA3 in A+3..A+6, `m_last` on 0xA3, `done` once.
- Fill at addr 126, len 4 → RAM[126], [127], [0], [1] written; the dump reads back identical data in wrapped order.
- Dump len 8 with `m_ready` toggling 1,0,0,1,… plus random `s_valid` gaps on a fill → no loss/duplication, and `occupancy` never exceeds 2.
- `cmd_len`=0 → `done` in A+1, `ram_we` never asserted. `cmd_len`=200 → exactly 128 beats.
- Assert `rst_n`=0 mid-dump with 3 words pending → next cycle `m_valid`=0, no `done`. After release, `cmd_ready`=1 and a new fill works.
- Back-to-back fill then dump, with `cmd_valid` held → the second handshake lands in the `done` cycle with no bubble.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared types and sizing for the 128x32 RAM burst front-end.
package ram_ctrl_pkg;

    localparam int RAM_DATA_W = 32;
    localparam int RAM_ADDR_W = 7;
    localparam int DEPTH      = 2 ** RAM_ADDR_W;
    localparam int LEN_W      = RAM_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_DRAIN
    } state_e;

endpackage

// File: rtl/ram_rd_skid.sv
// Two-entry buffer that absorbs the RAM read latency so stalled output never drops a word.
module ram_rd_skid
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic [1:0]            occ_o
);

    logic [DATA_WIDTH-1:0] d0_q, d0_d, d1_q, d1_d;
    logic                  l0_q, l0_d, l1_q, l1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop;

    assign pop     = pop_i && (occ_q != 2'd0);
    assign valid_o = (occ_q != 2'd0);
    assign data_o  = d0_q;
    assign last_o  = valid_o && l0_q;
    assign occ_o   = occ_q;

    always_comb begin
        d0_d  = d0_q;
        d1_d  = d1_q;
        l0_d  = l0_q;
        l1_d  = l1_q;
        occ_d = occ_q;
        unique case ({push_i, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    d0_d = push_data_i;
                    l0_d = push_last_i;
                end else begin
                    d1_d = push_data_i;
                    l1_d = push_last_i;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                d0_d  = d1_q;
                l0_d  = l1_q;
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Head leaves while a new word arrives: occupancy is unchanged.
                if (occ_q == 2'd1) begin
                    d0_d = push_data_i;
                    l0_d = push_last_i;
                end else begin
                    d0_d = d1_q;
                    l0_d = l1_q;
                    d1_d = push_data_i;
                    l1_d = push_last_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d0_q  <= '0;
            d1_q  <= '0;
            l0_q  <= 1'b0;
            l1_q  <= 1'b0;
            occ_q <= 2'd0;
        end else begin
            d0_q  <= d0_d;
            d1_q  <= d1_d;
            l0_q  <= l0_d;
            l1_q  <= l1_d;
            occ_q <= occ_d;
        end
    end

endmodule

// File: rtl/ram128x32_burst_ctrl.sv
// Burst fill/dump controller owning the single port of a 128x32 registered-read RAM.
module ram128x32_burst_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = RAM_DATA_W,
    parameter int ADDR_WIDTH = RAM_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_d,
    input  logic [DATA_WIDTH-1:0] ram_q
);

    localparam int                LW      = ADDR_WIDTH + 1;
    localparam logic [LW-1:0]     DEPTH_V = LW'(2 ** ADDR_WIDTH);
    localparam logic [LW-1:0]     ONE     = LW'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, hold_q, hold_d;
    logic [LW-1:0]         rem_q, rem_d, len_eff;
    logic                  done_q, done_d;
    logic                  infl_q, infl_d, infl_last_q, infl_last_d;
    logic [1:0]            occ;
    logic                  pop, beat, issue;

    assign len_eff = (cmd_len > DEPTH_V) ? DEPTH_V : cmd_len;
    assign pop     = m_valid && m_ready;
    assign beat    = (state_q == ST_WR) && s_valid;
    // Never issue a read whose data could find the buffer full a cycle later.
    assign issue   = (state_q == ST_RD_ISSUE) &&
                     (({1'b0, occ} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop}));

    assign cmd_ready   = rst_n && (state_q == ST_IDLE);
    assign s_ready     = (state_q == ST_WR);
    assign ram_we      = beat;
    assign ram_d       = s_data;
    assign ram_address = (state_q == ST_WR || state_q == ST_RD_ISSUE) ? addr_q : hold_q;
    assign done        = done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        hold_d      = hold_q;
        done_d      = 1'b0;
        infl_d      = issue;
        infl_last_d = issue && (rem_q == ONE);
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    addr_d = cmd_addr;
                    rem_d  = len_eff;
                    if (len_eff == '0) done_d = 1'b1;
                    else               state_d = cmd_wr ? ST_WR : ST_RD_ISSUE;
                end
            end
            ST_WR: begin
                if (beat) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - ONE;
                    hold_d = addr_q;
                    if (rem_q == ONE) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_RD_ISSUE: begin
                if (issue) begin
                    addr_d = addr_q + 1'b1;
                    rem_d  = rem_q - ONE;
                    hold_d = addr_q;
                    if (rem_q == ONE) state_d = ST_RD_DRAIN;
                end
            end
            ST_RD_DRAIN: begin
                // Finish as the final word leaves rather than a cycle later.
                if (!infl_q && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
        end
    end

    ram_rd_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (infl_q),
        .push_data_i (ram_q),
        .push_last_i (infl_last_q),
        .pop_i       (m_ready),
        .valid_o     (m_valid),
        .data_o      (m_data),
        .last_o      (m_last),
        .occ_o       (occ)
    );

endmodule

// File: tb/tb_ram128x32_burst_ctrl.sv
// Directed + randomized bench: a 128x32 registered-read RAM sits beside the DUT, a word array models its contents.
module tb_ram128x32_burst_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data;
    logic        done, ram_we;
    logic [6:0]  ram_address;
    logic [31:0] ram_d, ram_q;

    logic [31:0] ram_mem   [128];
    logic [31:0] mem_model [128];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_address] <= ram_d;
        ram_q <= ram_mem[ram_address];
    end

    ram128x32_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .done(done), .ram_we(ram_we), .ram_address(ram_address),
        .ram_d(ram_d), .ram_q(ram_q)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a command and return in the cycle after its handshake (A+1, just past the edge).
    task automatic send_cmd(input logic wr, input int addr, input int len);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_addr  = 7'(addr);
        cmd_len   = 8'(len);
        @(negedge clk);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accepted", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // chain: present a dump of the same region while the last beat is offered.
    task automatic fill_body(input int addr, input int len, input int base, input bit gaps,
                             input bit chain);
        int eff = (len > 128) ? 128 : len;
        int i = 0, cyc = 0;
        if (eff == 0) begin
            @(negedge clk);
            chk("len0_done", 32'(done), 32'd1);
            chk("len0_no_we", 32'(ram_we), 32'd0);
            chk("len0_sready", 32'(s_ready), 32'd0);
            @(posedge clk); #1;
            return;
        end
        while (i < eff && cyc < 1000) begin
            s_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data  = (base != 0) ? 32'(base + i) : $urandom;
            if (chain && i == eff - 1 && s_valid) begin
                cmd_valid = 1'b1;
                cmd_wr    = 1'b0;
                cmd_addr  = 7'(addr);
                cmd_len   = 8'(len);
            end
            @(negedge clk);
            if (cyc == 0) chk("fill_sready_a1", 32'(s_ready), 32'd1);
            if (s_valid) begin
                chk("fill_we", 32'(ram_we), 32'd1);
                chk("fill_addr", 32'(ram_address), 32'((addr + i) % 128));
                chk("fill_d", ram_d, s_data);
                mem_model[(addr + i) % 128] = s_data;
                i++;
            end else begin
                chk("fill_gap_we", 32'(ram_we), 32'd0);
            end
            chk("fill_no_early_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0;
        @(negedge clk);
        chk("fill_beats", 32'(i), 32'(eff));
        chk("fill_done", 32'(done), 32'd1);
        chk("fill_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("fill_sready_off", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        if (chain) cmd_valid = 1'b0;
    endtask

    // mode 0: m_ready=1, 1: repeating 1,0,0,1 pattern, 2: random
    task automatic dump_body(input int addr, input int len, input int mode);
        int eff = (len > 128) ? 128 : len;
        logic [31:0] exp_q[$];
        logic [3:0] pat = 4'b1001;
        int got = 0, cyc = 1, first_v = 0, last_beat = 0, done_cyc = 0;
        bit fin = 0;
        if (eff == 0) begin
            @(negedge clk);
            chk("dump0_done", 32'(done), 32'd1);
            chk("dump0_mvalid", 32'(m_valid), 32'd0);
            @(posedge clk); #1;
            return;
        end
        for (int j = 0; j < eff; j++) exp_q.push_back(mem_model[(addr + j) % 128]);
        while (!fin && cyc <= 600) begin
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = pat[(cyc - 1) % 4];
                default: m_ready = ($urandom_range(0, 1) != 0);
            endcase
            @(negedge clk);
            if (cyc == 1) chk("dump_addr_a1", 32'(ram_address), 32'(addr));
            if (m_valid && first_v == 0) first_v = cyc;
            if (m_valid && m_ready) begin
                if (got < eff) begin
                    chk("dump_data", m_data, exp_q[got]);
                    chk("dump_last", 32'(m_last), 32'(got == eff - 1));
                end
                got++;
                if (got == eff) last_beat = cyc;
            end
            if (done) begin
                done_cyc = cyc;
                fin = 1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        m_ready = 1'b1;
        chk("dump_done_seen", 32'(fin), 32'd1);
        chk("dump_count", 32'(got), 32'(eff));
        chk("dump_done_after_last", 32'(done_cyc > last_beat), 32'd1);
        if (mode == 0) begin
            chk("dump_first_valid_a3", 32'(first_v), 32'd3);
            chk("dump_last_beat", 32'(last_beat), 32'(eff + 2));
        end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_len = '0;
        s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_address", 32'(ram_address), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // basic fill/dump
        send_cmd(1'b1, 5, 4);  fill_body(5, 4, 32'hA0, 1'b0, 1'b0);
        send_cmd(1'b0, 5, 4);  dump_body(5, 4, 0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("idle_addr_hold", 32'(ram_address), 32'd8);
        @(posedge clk); #1;

        // address wrap
        send_cmd(1'b1, 126, 4); fill_body(126, 4, 0, 1'b0, 1'b0);
        send_cmd(1'b0, 126, 4); dump_body(126, 4, 0);

        // gaps on fill, back-pressure on dump
        send_cmd(1'b1, 40, 8); fill_body(40, 8, 0, 1'b1, 1'b0);
        send_cmd(1'b0, 40, 8); dump_body(40, 8, 1);

        // zero length and clamped length
        send_cmd(1'b1, 20, 0); fill_body(20, 0, 0, 1'b0, 1'b0);
        send_cmd(1'b0, 20, 0); dump_body(20, 0, 0);
        send_cmd(1'b1, 10, 200); fill_body(10, 200, 0, 1'b1, 1'b0);
        send_cmd(1'b0, 10, 200); dump_body(10, 200, 2);

        // reset mid-dump with the buffer holding words
        m_ready = 1'b0;
        send_cmd(1'b0, 40, 8);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid_m_valid", 32'(m_valid), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_hold_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("rst_release_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_release_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        send_cmd(1'b1, 60, 3); fill_body(60, 3, 0, 1'b0, 1'b0);
        send_cmd(1'b0, 60, 3); dump_body(60, 3, 2);

        // back-to-back: dump handshake lands in the fill's done cycle
        send_cmd(1'b1, 90, 5); fill_body(90, 5, 0, 1'b0, 1'b1);
        dump_body(90, 5, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
